// File: rtl/fme_arbiter_if.sv
// Requester, response and engine-side signal bundle for fme_arbiter.
// master = surrounding system (requesters and engine), slave = the arbiter.
interface fme_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_base;
    logic [WIDTH-1:0] req0_exp;
    logic [WIDTH-1:0] req0_mod;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_base;
    logic [WIDTH-1:0] req1_exp;
    logic [WIDTH-1:0] req1_mod;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;
    logic             rsp0_err;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;
    logic             rsp1_err;

    logic             fme_start;
    logic [WIDTH-1:0] fme_base;
    logic [WIDTH-1:0] fme_exponent;
    logic [WIDTH-1:0] fme_modulo;
    logic [WIDTH-1:0] fme_result;
    logic             fme_done;
    logic             fme_soft_rst;

    modport master (
        output req0_valid, req0_base, req0_exp, req0_mod,
               req1_valid, req1_base, req1_exp, req1_mod,
               rsp0_ready, rsp1_ready, fme_result, fme_done,
        input  req0_ready, req1_ready,
               rsp0_valid, rsp0_result, rsp0_err,
               rsp1_valid, rsp1_result, rsp1_err,
               fme_start, fme_base, fme_exponent, fme_modulo, fme_soft_rst
    );

    modport slave (
        input  req0_valid, req0_base, req0_exp, req0_mod,
               req1_valid, req1_base, req1_exp, req1_mod,
               rsp0_ready, rsp1_ready, fme_result, fme_done,
        output req0_ready, req1_ready,
               rsp0_valid, rsp0_result, rsp0_err,
               rsp1_valid, rsp1_result, rsp1_err,
               fme_start, fme_base, fme_exponent, fme_modulo, fme_soft_rst
    );
endinterface

// File: rtl/fme_arbiter.sv
// Round-robin arbiter sharing one modular-exponentiation engine between two requesters.
// Optional WAIT watchdog (abort with err + engine soft reset) enabled by FME_WATCHDOG_EN.
module fme_arbiter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    fme_arbiter_if.slave bus,
    output logic         busy,
    output logic         grant_id
);

`ifdef FME_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        base_q, base_d;
    logic [WIDTH-1:0]        exp_q, exp_d;
    logic [WIDTH-1:0]        mod_q, mod_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [1:0]              rsp_err_q, rsp_err_d;
    logic [1:0][WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic [CNT_W-1:0]        wd_cnt_q, wd_cnt_d;
    logic                    soft_rst_q, soft_rst_d;

    logic                    elig0, elig1, sel;
    logic [WIDTH-1:0]        sel_base, sel_exp, sel_mod;
    logic [1:0]              rsp_ready;

    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        exp_d        = exp_q;
        mod_d        = mod_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_result_d = rsp_result_q;
        wd_cnt_d     = wd_cnt_q;
        soft_rst_d   = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;

        // Eligibility uses the registered response valid, so a consumer's ready cannot free its port early.
        elig0    = bus.req0_valid && !rsp_valid_q[0];
        elig1    = bus.req1_valid && !rsp_valid_q[1];
        sel      = (elig0 && elig1) ? !last_grant_q : elig1;
        sel_base = sel ? bus.req1_base : bus.req0_base;
        sel_exp  = sel ? bus.req1_exp  : bus.req0_exp;
        sel_mod  = sel ? bus.req1_mod  : bus.req0_mod;

        for (int i = 0; i < 2; i++) begin
            if (rsp_valid_q[i] && rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (elig0 || elig1) begin
                    bus.req0_ready = !sel;
                    bus.req1_ready = sel;
                    base_d         = sel_base;
                    exp_d          = sel_exp;
                    mod_d          = sel_mod;
                    grant_d        = sel;
                    last_grant_d   = sel;
                    // Modulus 0 or 1 always yields 0; answer directly without occupying the engine.
                    if (sel_mod[WIDTH-1:1] == '0) begin
                        rsp_valid_d[sel]  = 1'b1;
                        rsp_result_d[sel] = '0;
                        rsp_err_d[sel]    = 1'b0;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                state_d  = S_WAIT;
                wd_cnt_d = '0;
            end
            S_WAIT: begin
                if (bus.fme_done) begin
                    rsp_valid_d[grant_q]  = 1'b1;
                    rsp_result_d[grant_q] = bus.fme_result;
                    rsp_err_d[grant_q]    = 1'b0;
                    state_d               = S_IDLE;
                end else if (WD_EN) begin
                    if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_d[grant_q]  = 1'b1;
                        rsp_result_d[grant_q] = '0;
                        rsp_err_d[grant_q]    = 1'b1;
                        soft_rst_d            = 1'b1;
                        state_d               = S_IDLE;
                    end else begin
                        wd_cnt_d = wd_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            exp_q        <= '0;
            mod_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= '0;
            rsp_err_q    <= '0;
            rsp_result_q <= '0;
            wd_cnt_q     <= '0;
            soft_rst_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            exp_q        <= exp_d;
            mod_q        <= mod_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_result_q <= rsp_result_d;
            wd_cnt_q     <= wd_cnt_d;
            soft_rst_q   <= soft_rst_d;
        end
    end

    assign bus.rsp0_valid   = rsp_valid_q[0];
    assign bus.rsp0_result  = rsp_result_q[0];
    assign bus.rsp0_err     = rsp_err_q[0];
    assign bus.rsp1_valid   = rsp_valid_q[1];
    assign bus.rsp1_result  = rsp_result_q[1];
    assign bus.rsp1_err     = rsp_err_q[1];
    assign bus.fme_start    = (state_q == S_LAUNCH);
    assign bus.fme_base     = base_q;
    assign bus.fme_exponent = exp_q;
    assign bus.fme_modulo   = mod_q;
    assign bus.fme_soft_rst = soft_rst_q;
    assign busy             = (state_q != S_IDLE);
    assign grant_id         = grant_q;

endmodule

// File: tb/tb_fme_arbiter.sv
// Scoreboard bench for fme_arbiter: per-port job drivers, a behavioural engine model,
// and expected grants/responses queued at stimulus time and compared as the DUT produces them.
module tb_fme_arbiter;
    localparam int WIDTH = 32;
`ifdef FME_WATCHDOG_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 4096;
`endif

    typedef struct {
        logic [WIDTH-1:0] base;
        logic [WIDTH-1:0] ex;
        logic [WIDTH-1:0] md;
    } job_t;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic grant_id;

    fme_arbiter_if #(.WIDTH(WIDTH)) bus ();

    fme_arbiter #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    job_t jobs0[$];
    job_t jobs1[$];
    rsp_t exp0[$];
    rsp_t exp1[$];
    int   exp_grant[$];

    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    bit   acc0 = 1'b0;
    bit   acc1 = 1'b0;
    bit   eng_hang = 1'b0;
    int   eng_lat = 3;
    int   start_count = 0;
    int   soft_cnt = 0;
    int   start_cyc = 0;
    int   done_cyc = 0;
    int   acc_cyc[2] = '{0, 0};
    int   rise_cyc[2] = '{0, 0};
    logic [1:0] prev_v = 2'b00;
    logic [3*WIDTH-1:0] done_ops = '0;
    logic [WIDTH-1:0] eng_r;

    function automatic logic [WIDTH-1:0] modexp(input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] e,
                                               input logic [WIDTH-1:0] m);
        longint unsigned r, x, mm;
        logic [WIDTH-1:0] ee;
        if (m[WIDTH-1:1] == '0) return '0;
        mm = 64'(m);
        x  = 64'(b) % mm;
        r  = 64'd1;
        ee = e;
        while (ee != '0) begin
            if (ee[0]) r = (r * x) % mm;
            x  = (x * x) % mm;
            ee = ee >> 1;
        end
        return WIDTH'(r);
    endfunction

    always @(posedge clk) cycle++;

    // Requester 0 driver: presents the head of jobs0 until the monitor sees it accepted.
    always begin
        @(posedge clk);
        #1;
        if (acc0) begin
            if (jobs0.size() > 0) void'(jobs0.pop_front());
            acc0 = 1'b0;
        end
        if (jobs0.size() > 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_base  = jobs0[0].base;
            bus.req0_exp   = jobs0[0].ex;
            bus.req0_mod   = jobs0[0].md;
        end else begin
            bus.req0_valid = 1'b0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (acc1) begin
            if (jobs1.size() > 0) void'(jobs1.pop_front());
            acc1 = 1'b0;
        end
        if (jobs1.size() > 0) begin
            bus.req1_valid = 1'b1;
            bus.req1_base  = jobs1[0].base;
            bus.req1_exp   = jobs1[0].ex;
            bus.req1_mod   = jobs1[0].md;
        end else begin
            bus.req1_valid = 1'b0;
        end
    end

    // Engine model: computes the result from the operands seen at start, answers eng_lat cycles later.
    always begin
        @(posedge clk);
        #2;
        if (bus.fme_start && !eng_hang) begin
            eng_r = modexp(bus.fme_base, bus.fme_exponent, bus.fme_modulo);
            repeat (eng_lat) @(posedge clk);
            #2;
            bus.fme_done   = 1'b1;
            bus.fme_result = eng_r;
            @(posedge clk);
            #2;
            bus.fme_done   = 1'b0;
            bus.fme_result = '0;
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        int   g;
        int   eg;
        if (!rst) begin
            if (bus.req0_valid && bus.req0_ready) begin
                acc0 = 1'b1;
                acc_cyc[0] = cycle;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                acc1 = 1'b1;
                acc_cyc[1] = cycle;
            end
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
                total++;
                g = (bus.req1_valid && bus.req1_ready) ? 1 : 0;
                if (bus.req0_ready && bus.req1_ready) begin
                    bad++;
                    $display("[TB] FAIL grant_both_ready got=11 expected one-hot");
                end else if (exp_grant.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL grant_unexpected got=%0d expected=none", g);
                end else begin
                    eg = exp_grant.pop_front();
                    if (g != eg) begin
                        bad++;
                        $display("[TB] FAIL grant_order got=%0d expected=%0d", g, eg);
                    end
                end
            end
            if (bus.fme_start) begin
                start_count++;
                start_cyc = cycle;
            end
            if (bus.fme_done && busy) begin
                done_cyc = cycle;
                done_ops = {bus.fme_base, bus.fme_exponent, bus.fme_modulo};
            end
            if (bus.fme_soft_rst) soft_cnt++;
            if (bus.rsp0_valid && !prev_v[0]) rise_cyc[0] = cycle;
            if (bus.rsp1_valid && !prev_v[1]) rise_cyc[1] = cycle;
            prev_v = {bus.rsp1_valid, bus.rsp0_valid};

            if (bus.rsp0_valid && bus.rsp0_ready) begin
                total++;
                if (exp0.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL rsp0_unexpected got result=%0d err=%0d expected=none",
                             bus.rsp0_result, bus.rsp0_err);
                end else begin
                    e = exp0.pop_front();
                    if (bus.rsp0_result !== e.result || bus.rsp0_err !== e.err) begin
                        bad++;
                        $display("[TB] FAIL rsp0_data got result=%0d err=%0d expected result=%0d err=%0d",
                                 bus.rsp0_result, bus.rsp0_err, e.result, e.err);
                    end
                end
            end
            if (bus.rsp1_valid && bus.rsp1_ready) begin
                total++;
                if (exp1.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL rsp1_unexpected got result=%0d err=%0d expected=none",
                             bus.rsp1_result, bus.rsp1_err);
                end else begin
                    e = exp1.pop_front();
                    if (bus.rsp1_result !== e.result || bus.rsp1_err !== e.err) begin
                        bad++;
                        $display("[TB] FAIL rsp1_data got result=%0d err=%0d expected result=%0d err=%0d",
                                 bus.rsp1_result, bus.rsp1_err, e.result, e.err);
                    end
                end
            end
        end else begin
            prev_v = 2'b00;
        end
    end

    task automatic push_job(input int port, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e,
                            input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] res, input logic err);
        job_t j;
        rsp_t r;
        j.base = b;
        j.ex = e;
        j.md = m;
        r.result = res;
        r.err = err;
        if (port == 0) begin
            jobs0.push_back(j);
            exp0.push_back(r);
        end else begin
            jobs1.push_back(j);
            exp1.push_back(r);
        end
    endtask

    task automatic clear_queues();
        jobs0.delete();
        jobs1.delete();
        exp0.delete();
        exp1.delete();
        exp_grant.delete();
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_queues();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (jobs0.size() == 0 && jobs1.size() == 0 && exp0.size() == 0 && exp1.size() == 0 &&
                !busy && !bus.rsp0_valid && !bus.rsp1_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (busy !== 1'b0 || grant_id !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state got busy=%b grant=%b expected 0 0", busy, grant_id);
        end
        total++;
        if ({bus.fme_start, bus.fme_soft_rst} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_engine_ctl got=%b expected=00", {bus.fme_start, bus.fme_soft_rst});
        end
        total++;
        if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_err, bus.rsp0_err} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_rsp_flags got=%b expected=0000",
                     {bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_err, bus.rsp0_err});
        end
        total++;
        if (bus.rsp0_result !== '0 || bus.rsp1_result !== '0) begin
            bad++;
            $display("[TB] FAIL reset_rsp_result got=%0d,%0d expected=0,0", bus.rsp0_result, bus.rsp1_result);
        end
        total++;
        if ({bus.fme_base, bus.fme_exponent, bus.fme_modulo} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_operands got=%h expected=0", {bus.fme_base, bus.fme_exponent, bus.fme_modulo});
        end
    endtask

    task automatic test_single_job();
        bit ok;
        int sc;
        sc = start_count;
        @(negedge clk);
        push_job(0, 32'd4, 32'd13, 32'd497, 32'd445, 1'b0);
        exp_grant.push_back(0);
        wait_drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL single_drain got=timeout expected=drained");
        end
        total++;
        if (start_count != sc + 1) begin
            bad++;
            $display("[TB] FAIL single_start_count got=%0d expected=%0d", start_count - sc, 1);
        end
        total++;
        if (start_cyc != acc_cyc[0] + 1) begin
            bad++;
            $display("[TB] FAIL single_start_latency got=%0d expected=%0d", start_cyc - acc_cyc[0], 1);
        end
        total++;
        if (rise_cyc[0] != done_cyc + 1) begin
            bad++;
            $display("[TB] FAIL single_rsp_latency got=%0d expected=%0d", rise_cyc[0] - done_cyc, 1);
        end
        total++;
        if (done_ops !== {32'd4, 32'd13, 32'd497}) begin
            bad++;
            $display("[TB] FAIL single_operands got=%h expected=%h", done_ops, {32'd4, 32'd13, 32'd497});
        end
    endtask

    task automatic test_contention();
        bit ok;
        int sc;
        do_reset();
        sc = start_count;
        @(negedge clk);
        push_job(0, 32'd5, 32'd3, 32'd13, 32'd8, 1'b0);
        push_job(0, 32'd7, 32'd2, 32'd11, 32'd5, 1'b0);
        push_job(1, 32'd2, 32'd10, 32'd1000, 32'd24, 1'b0);
        push_job(1, 32'd3, 32'd4, 32'd7, 32'd4, 1'b0);
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        wait_drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL contention_drain got=timeout expected=drained");
        end
        total++;
        if (start_count != sc + 4) begin
            bad++;
            $display("[TB] FAIL contention_starts got=%0d expected=%0d", start_count - sc, 4);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit found;
        int viol;
        int set_cyc;
        @(posedge clk);
        #1;
        bus.rsp0_ready = 1'b0;
        @(negedge clk);
        push_job(0, 32'd3, 32'd5, 32'd100, 32'd43, 1'b0);
        exp_grant.push_back(0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp0_valid) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL bp_first_rsp got=timeout expected=rsp0_valid");
        end
        @(negedge clk);
        push_job(0, 32'd6, 32'd2, 32'd35, 32'd1, 1'b0);
        push_job(1, 32'd9, 32'd2, 32'd50, 32'd31, 1'b0);
        exp_grant.push_back(1);
        exp_grant.push_back(0);
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.req0_ready) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("[TB] FAIL bp_req0_blocked got=%0d grants expected=0", viol);
        end
        total++;
        if (exp1.size() != 0) begin
            bad++;
            $display("[TB] FAIL bp_req1_served got=%0d pending expected=0", exp1.size());
        end
        total++;
        if (jobs0.size() != 1) begin
            bad++;
            $display("[TB] FAIL bp_req0_waiting got=%0d queued expected=1", jobs0.size());
        end
        @(posedge clk);
        #1;
        bus.rsp0_ready = 1'b1;
        set_cyc = cycle;
        wait_drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL bp_drain got=timeout expected=drained");
        end
        total++;
        if (acc_cyc[0] != set_cyc + 1) begin
            bad++;
            $display("[TB] FAIL bp_accept_cycle got=%0d expected=%0d", acc_cyc[0] - set_cyc, 1);
        end
    endtask

    task automatic test_bypass();
        bit ok;
        int sc;
        sc = start_count;
        @(negedge clk);
        push_job(1, 32'hdead, 32'd7, 32'd1, 32'd0, 1'b0);
        push_job(1, 32'h1234, 32'd3, 32'd0, 32'd0, 1'b0);
        exp_grant.push_back(1);
        exp_grant.push_back(1);
        wait_drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL bypass_drain got=timeout expected=drained");
        end
        total++;
        if (start_count != sc) begin
            bad++;
            $display("[TB] FAIL bypass_no_start got=%0d starts expected=0", start_count - sc);
        end
        total++;
        if (rise_cyc[1] != acc_cyc[1] + 1) begin
            bad++;
            $display("[TB] FAIL bypass_latency got=%0d expected=%0d", rise_cyc[1] - acc_cyc[1], 1);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        bit found;
        job_t j;
        eng_hang = 1'b1;
        j.base = 32'd3;
        j.ex = 32'd3;
        j.md = 32'd10;
        @(negedge clk);
        jobs0.push_back(j);
        exp_grant.push_back(0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (busy && !bus.fme_start) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL rmw_reach_wait got=timeout expected=WAIT");
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_queues();
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({busy, bus.fme_start, grant_id, bus.rsp0_valid, bus.rsp1_valid} !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL rmw_outputs got=%b expected=00000",
                     {busy, bus.fme_start, grant_id, bus.rsp0_valid, bus.rsp1_valid});
        end
        total++;
        if ({bus.fme_base, bus.fme_exponent, bus.fme_modulo} !== '0) begin
            bad++;
            $display("[TB] FAIL rmw_operands got=%h expected=0", {bus.fme_base, bus.fme_exponent, bus.fme_modulo});
        end
        eng_hang = 1'b0;
        @(negedge clk);
        push_job(0, 32'd2, 32'd5, 32'd7, 32'd4, 1'b0);
        push_job(1, 32'd3, 32'd2, 32'd5, 32'd4, 1'b0);
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        wait_drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL rmw_drain got=timeout expected=drained");
        end
    endtask

`ifdef FME_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok;
        int sc;
        eng_hang = 1'b1;
        sc = soft_cnt;
        @(negedge clk);
        push_job(0, 32'd4, 32'd13, 32'd497, 32'd0, 1'b1);
        exp_grant.push_back(0);
        wait_drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL wd_drain got=timeout expected=drained");
        end
        total++;
        if (soft_cnt != sc + 1) begin
            bad++;
            $display("[TB] FAIL wd_soft_rst got=%0d pulses expected=1", soft_cnt - sc);
        end
        total++;
        if (rise_cyc[0] != start_cyc + TIMEOUT + 1) begin
            bad++;
            $display("[TB] FAIL wd_latency got=%0d expected=%0d", rise_cyc[0] - start_cyc, TIMEOUT + 1);
        end
        eng_hang = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout got=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_base = '0;
        bus.req0_exp = '0;
        bus.req0_mod = '0;
        bus.req1_valid = 1'b0;
        bus.req1_base = '0;
        bus.req1_exp = '0;
        bus.req1_mod = '0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        bus.fme_done = 1'b0;
        bus.fme_result = '0;
        $display("[TB] starting fme_arbiter bench");
        test_reset();
        test_single_job();
        test_contention();
        test_backpressure();
        test_bypass();
        test_reset_mid_wait();
`ifdef FME_WATCHDOG_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fme_arbiter.md
Name: fme_arbiter

Overview:
- Two-port round-robin arbiter that shares one modular-exponentiation engine between two requesters, e.g. the encrypt and decrypt paths of the RSA core.
- Accepts (base, exponent, modulo) jobs over valid/ready and launches the engine with a one-cycle start pulse.
- Holds engine operands stable while the engine runs, and returns each result to the owning requester through a valid/ready response register.
- Sits between the RSA top-level controllers and the single engine instance.

Parameters:
- WIDTH, 32, operand/result width; must match engine.
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid / req1_valid  in  1  job request, requester 0 / 1
- req0_ready / req1_ready  out  1  job accepted this cycle (combinational)
- req0_base, req0_exp, req0_mod / req1_*  in  WIDTH  job operands
- rsp0_valid / rsp1_valid  out  1  result pending
- rsp0_ready / rsp1_ready  in  1  result consumed
- rsp0_result / rsp1_result  out  WIDTH  result
- rsp0_err / rsp1_err  out  1  job aborted (watchdog)
- fme_start  out  1  one-cycle engine start
- fme_base, fme_exponent, fme_modulo  out  WIDTH  engine operands
- fme_result  in  WIDTH  engine result
- fme_done  in  1  engine done pulse; fme_result valid in the same cycle
- fme_soft_rst  out  1  engine reset request; ORed with rst externally
- busy  out  1  state != IDLE
- grant_id  out  1  owner of current job

Behaviour:
- Reset (synchronous, active-high clock sample):
  - State IDLE; all outputs 0.
  - Job operand regs 0; last_grant = 1, so requester 0 wins first.
  - Pending responses are discarded.
  - Reset mid-job abandons the job silently.
- Eligibility: eligN = reqN_valid && !rspN_valid, using the registered rspN_valid.
  - A requester whose response is pending is never granted.
  - This holds even if rspN_ready is high in the same cycle.
- State IDLE:
  - Neither requester eligible: stay in IDLE.
  - One requester eligible: grant it.
  - Both eligible: grant the one != last_grant.
  - Granted reqN_ready = 1 in the same cycle; the other ready stays 0.
  - On grant: capture operands into job regs, set grant_id and last_grant.
  - If mod <= 1: bypass the engine. Next cycle rspN_valid = 1, rspN_result = 0, rspN_err = 0; state stays IDLE.
  - Otherwise go to LAUNCH.
- State LAUNCH: fme_start = 1 for exactly this cycle; go to WAIT.
- State WAIT:
  - On fme_done: rsp[grant_id]_result <= fme_result, rsp_valid <= 1, err <= 0; go to IDLE.
  - A new grant is possible in the IDLE cycle that follows.
- fme_base/fme_exponent/fme_modulo:
  - Driven from the job regs at all times.
  - Stable from LAUNCH until the cycle after fme_done.
- fme_done in IDLE or LAUNCH is ignored.
- Response register:
  - rspN_valid stays high until the cycle rspN_ready is sampled high; cleared the next edge.
  - result and err are held while valid is high.
- Latency (engine path):
  - Accept at cycle T, fme_start at T+1, WAIT from T+2.
  - fme_done at cycle D gives rspN_valid = 1 at D+1.
- Latency (bypass path): response at T+1.
- busy = 1 in LAUNCH and WAIT.
- Each response goes to its own requester; responses never cross ports.

Optional Feature:
- Macro FME_WATCHDOG_EN.
- Defined:
  - A WAIT cycle counter is cleared on entry to WAIT.
  - If the counter reaches TIMEOUT_CYCLES without fme_done: rsp[grant_id]_valid = 1, result = 0, err = 1.
  - fme_soft_rst = 1 for one cycle; state goes to IDLE.
  - fme_done and timeout in the same cycle: fme_done wins.
- Undefined: no counter; rspN_err and fme_soft_rst are tied 0; WAIT waits indefinitely.

Test Plan:
- Single job: req0 base=4, exp=13, mod=497 with model engine → fme_start at T+1; rsp0_valid one cycle after fme_done; rsp0_result=445, rsp0_err=0.
- Contention: req0 and req1 held valid continuously, rsp_ready=1, jobs 5^3 mod 13 and 2^10 mod 1000 → grants alternate 0,1,0,1; results 8 and 24 on the correct ports.
- Backpressure: rsp0_ready=0 with req0 re-asserted → req0 not granted; req1 still served; after rsp0_ready=1, req0 is accepted the next IDLE.
- Bypass: req1 mod=1 then mod=0 → no fme_start; rsp1_valid at T+1 with result 0 both times.
- Reset mid-WAIT: rst in WAIT → next cycle all outputs 0 and state IDLE; a new req0 is granted first.
- Watchdog (FME_WATCHDOG_EN, TIMEOUT_CYCLES=16): engine never asserts done → after 16 WAIT cycles rsp0_err=1, rsp0_result=0, fme_soft_rst pulses once.
